// File: rtl/segmax_row_ctrl.sv
// Row-wide segmented running-max sequencer feeding the softmax subtract stage.
// Splits each 16-lane int8 beat into 2/4/8 segments and tracks per-segment max.
module segmax_row_ctrl #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int LEN_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_cfg_seg,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [LANES*DW-1:0] i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [8*DW-1:0]    o_out_max,
  output logic [3:0]         o_out_nseg,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_t;

  localparam logic [1:0] SEG2 = 2'd0;
  localparam logic [1:0] SEG4 = 2'd1;
  localparam logic [1:0] SEG8 = 2'd2;

  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_seg;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [8*DW-1:0]  r_out_max;
  logic [3:0]       r_out_nseg;

  logic signed [DW-1:0] r_max  [8];
  logic signed [DW-1:0] w_lane [LANES];
  logic signed [DW-1:0] w_l1   [8];
  logic signed [DW-1:0] w_l2   [4];
  logic signed [DW-1:0] w_l3   [2];
  logic signed [DW-1:0] w_seg  [8];
  logic signed [DW-1:0] w_new  [8];

  logic            w_accept;
  logic            w_last;
  logic            w_start;
  logic [3:0]      w_nseg;
  logic [8*DW-1:0] w_out;

  // Ties keep the earlier operand; the value is the same either way.
  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane[i] = i_in_data[DW*i +: DW];
    end
    for (int j = 0; j < 8; j++) begin
      w_l1[j] = smax(w_lane[2*j], w_lane[2*j+1]);
    end
    for (int j = 0; j < 4; j++) begin
      w_l2[j] = smax(w_l1[2*j], w_l1[2*j+1]);
    end
    for (int j = 0; j < 2; j++) begin
      w_l3[j] = smax(w_l2[2*j], w_l2[2*j+1]);
    end
  end

  // Unused segment slots see the preset value so they never move.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_seg[k] = MINV;
    end
    unique case (r_seg)
      SEG8: begin
        for (int k = 0; k < 8; k++) begin
          w_seg[k] = w_l1[k];
        end
      end
      SEG4: begin
        for (int k = 0; k < 4; k++) begin
          w_seg[k] = w_l2[k];
        end
      end
      default: begin
        for (int k = 0; k < 2; k++) begin
          w_seg[k] = w_l3[k];
        end
      end
    endcase
  end

  always_comb begin
    unique case (r_seg)
      SEG8:    w_nseg = 4'd8;
      SEG4:    w_nseg = 4'd4;
      default: w_nseg = 4'd2;
    endcase
  end

  always_comb begin
    w_out = '0;
    for (int k = 0; k < 8; k++) begin
      w_new[k] = smax(r_max[k], w_seg[k]);
      if (4'(k) < w_nseg) begin
        w_out[DW*k +: DW] = w_new[k];
      end
    end
  end

  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_accept = (r_state == S_ACCUM) && i_in_valid;
  assign w_last   = w_accept &&
                    (r_cnt == r_len - LEN_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_last) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        if (i_out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg      <= SEG2;
      r_len      <= LEN_W'(1);
      r_cnt      <= '0;
      r_out_max  <= '0;
      r_out_nseg <= '0;
      for (int k = 0; k < 8; k++) begin
        r_max[k] <= MINV;
      end
    end else begin
      if (w_start) begin
        r_seg <= (i_cfg_seg == 2'd3) ? SEG2 : i_cfg_seg;
        r_len <= (i_cfg_len == '0) ? LEN_W'(1) : i_cfg_len;
        r_cnt <= '0;
        for (int k = 0; k < 8; k++) begin
          r_max[k] <= MINV;
        end
      end
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + LEN_W'(1);
        for (int k = 0; k < 8; k++) begin
          r_max[k] <= w_new[k];
        end
      end
      // Result snapshot includes the final beat; held until the next row ends.
      if (w_last) begin
        r_out_max  <= w_out;
        r_out_nseg <= w_nseg;
      end
    end
  end

  assign o_out_max  = r_out_max;
  assign o_out_nseg = r_out_nseg;

endmodule

// File: tb/tb_segmax_row_ctrl.sv
// Directed bench for segmax_row_ctrl.
// Hand-computed per-segment maxima checked with immediate assertions.
module tb_segmax_row_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   seg;
  logic [7:0]   len;
  logic         iv;
  logic         irdy;
  logic [127:0] d;
  logic         ov;
  logic         ordy;
  logic [63:0]  om;
  logic [3:0]   ns;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  segmax_row_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_cfg_seg   (seg),
    .i_cfg_len   (len),
    .i_in_valid  (iv),
    .o_in_ready  (irdy),
    .i_in_data   (d),
    .o_out_valid (ov),
    .i_out_ready (ordy),
    .o_out_max   (om),
    .o_out_nseg  (ns),
    .o_busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic begin_row(input logic [1:0] s, input logic [7:0] l);
    seg   = s;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    seg   = 2'd0;
    len   = 8'd0;
    iv    = 1'b0;
    d     = '0;
    ordy  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_irdy", 64'(irdy), 64'd0);
    chk("rst_ov",   64'(ov),   64'd0);
    chk("rst_om",   om,        64'd0);
    chk("rst_ns",   64'(ns),   64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // T1: two 8-lane segments, single beat
    begin_row(2'd0, 8'd1);
    chk("t1_irdy", 64'(irdy), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("t1_ov",   64'(ov),   64'd1);
    chk("t1_irdy_lo", 64'(irdy), 64'd0);
    chk("t1_om",   om,        64'h0000_0000_0000_0F07);
    chk("t1_ns",   64'(ns),   64'd2);
    handshake();
    chk("t1_ov_lo", 64'(ov),  64'd0);
    chk("t1_keep", om,        64'h0000_0000_0000_0F07);
    chk("t1_idle", 64'(busy), 64'd0);

    // T2: eight pair segments, 3 beats, lane i = i-8+b
    begin_row(2'd2, 8'd3);
    iv = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i - 8 + b);
      tick();
    end
    iv = 1'b0;
    chk("t2_ov",   64'(ov),   64'd1);
    chk("t2_irdy", 64'(irdy), 64'd0);
    chk("t2_om",   om,        64'h0907_0503_01FF_FDFB);
    chk("t2_ns",   64'(ns),   64'd8);
    handshake();

    // T3: all -128 rows, then sign check
    begin_row(2'd1, 8'd4);
    d  = {16{8'h80}};
    iv = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    iv = 1'b0;
    chk("t3_om", om,      64'h0000_0000_8080_8080);
    chk("t3_ns", 64'(ns), 64'd4);
    handshake();
    begin_row(2'd1, 8'd1);
    d = {16{8'h80}};
    d[7:0]   = 8'h7F;
    d[39:32] = 8'hFF;
    d[47:40] = 8'h01;
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("t3_sign", om, 64'h0000_0000_8080_017F);
    handshake();

    // T4: backpressure in OUT, start ignored while busy
    begin_row(2'd0, 8'd2);
    iv = 1'b1;
    d = {16{8'h10}};
    d[31:24] = 8'h40;
    tick();
    d = {16{8'h05}};
    d[103:96] = 8'h7E;
    tick();
    iv = 1'b0;
    seg   = 2'd2;
    len   = 8'd5;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_ov", 64'(ov), 64'd1);
      chk("t4_hold_om", om,      64'h0000_0000_0000_7E40);
      tick();
    end
    chk("t4_ns", 64'(ns), 64'd2);
    ordy = 1'b1;
    tick();
    ordy  = 1'b0;
    start = 1'b0;
    chk("t4_ov_lo", 64'(ov),   64'd0);
    chk("t4_idle",  64'(busy), 64'd0);
    tick();
    chk("t4_no_row", 64'(busy), 64'd0);
    chk("t4_ns_keep", 64'(ns),  64'd2);

    // T5: reset mid-row
    begin_row(2'd1, 8'd4);
    d  = {16{8'h70}};
    iv = 1'b1;
    tick();
    tick();
    iv  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_om",   om,        64'd0);
    chk("t5_ns",   64'(ns),   64'd0);
    chk("t5_ov",   64'(ov),   64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_irdy", 64'(irdy), 64'd0);
    begin_row(2'd1, 8'd1);
    d = {16{8'h01}};
    d[7:0] = 8'h02;
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("t5_fresh", om,      64'h0000_0000_0101_0102);
    chk("t5_ns4",   64'(ns), 64'd4);
    handshake();

    // T6: len 0 acts as 1, then gapped valid over 4 beats
    begin_row(2'd2, 8'd0);
    d  = {16{8'h33}};
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("t6_len0_ov", 64'(ov), 64'd1);
    chk("t6_len0_om", om,      64'h3333_3333_3333_3333);
    chk("t6_len0_ns", 64'(ns), 64'd8);
    handshake();
    begin_row(2'd0, 8'd4);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(j*10 - i);
      iv = 1'b1;
      tick();
      iv = 1'b0;
      d  = {16{8'h7F}};
      if (j < 3) begin
        chk("t6_gap_ov",   64'(ov),   64'd0);
        chk("t6_gap_irdy", 64'(irdy), 64'd1);
        tick();
      end
    end
    chk("t6_ov", 64'(ov), 64'd1);
    chk("t6_om", om,      64'h0000_0000_0000_161E);
    chk("t6_ns", 64'(ns), 64'd2);
    handshake();
    chk("t6_end", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
